// File: rtl/seq_det_frame_ctrl.sv
// Purpose: frame sequencer for a gated 1100 Mealy detector. It serialises
//          words MSB-first into the detector and counts hits over each frame.
// Latency: the first word is accepted 2 cycles after in_valid is seen in IDLE.
//          Each word then takes W shift cycles plus one LOAD bubble. res_valid
//          rises 2 cycles after the final shift cycle.
// Backpressure: in_ready is high only in LOAD. The result is held in REPORT
//          until res_ready is high. Neither ready/valid depends on its partner.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid/in_ready   word handshake; in_data (W bits) and in_last are
//                       sampled together
//   det_rst/det_en/det_x  detector reset, bit enable and serial bit
//   det_z               registered hit pulse returned by the detector
//   res_valid/res_ready result handshake; res_count is the saturating hit
//                       count, and res_sat is set if the count saturated
module seq_det_frame_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             det_rst,
    output logic             det_en,
    output logic             det_x,
    input  logic             det_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_sat
);

    localparam int BW = $clog2(W);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLR    = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] SHIFT  = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;
    localparam logic [2:0] REPORT = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [W-1:0]     sreg_q;
    logic [BW-1:0]    bcnt_q;
    logic             last_q;
    logic [CNT_W-1:0] hit_q;
    logic             sat_q;
    logic             count_en;

    // Hits are only meaningful while a frame is live. DRAIN is included so the
    // registered pulse from the final bit is still counted.
    assign count_en = (state_q == LOAD) || (state_q == SHIFT) || (state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CLR;
            CLR:     state_d = LOAD;
            LOAD:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (bcnt_q == '0) state_d = last_q ? DRAIN : LOAD;
            DRAIN:   state_d = REPORT;
            REPORT:  if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bcnt_q  <= '0;
            last_q  <= 1'b0;
            hit_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == LOAD && in_valid) begin
                sreg_q <= in_data;
                last_q <= in_last;
                bcnt_q <= BW'(W - 1);
            end else if (state_q == SHIFT) begin
                sreg_q <= {sreg_q[W-2:0], 1'b0};
                if (bcnt_q != '0) begin
                    bcnt_q <= bcnt_q - BW'(1);
                end
            end

            if (state_q == CLR) begin
                hit_q <= '0;
                sat_q <= 1'b0;
            end else if (count_en && det_z) begin
                if (hit_q == CNT_MAX) begin
                    sat_q <= 1'b1;
                end else begin
                    hit_q <= hit_q + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign det_en    = (state_q == SHIFT);
    assign det_x     = det_en & sreg_q[W-1];
    // The detector is held in reset alongside this block, as well as during CLR.
    assign det_rst   = (state_q == CLR) || !rst_n;
    assign res_valid = (state_q == REPORT);
    assign res_count = hit_q;
    assign res_sat   = sat_q;

endmodule

// File: tb/tb_seq_det_frame_ctrl.sv
module tb_seq_det_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       res_ready;

    logic       in_ready_a, det_rst_a, det_en_a, det_x_a, det_z_a, res_valid_a, res_sat_a;
    logic [7:0] res_count_a;
    logic       in_ready_b, det_rst_b, det_en_b, det_x_b, det_z_b, res_valid_b, res_sat_b;
    logic [1:0] res_count_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_shift_cyc = 0;
    int rst_pulses  = 0;

    typedef struct {
        int ca;
        bit sa;
        int cb;
        bit sb;
    } exp_t;

    exp_t res_q[$];
    bit   bit_q[$];
    logic [7:0] fw[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wide-counter instance and narrow-counter instance share all inputs.
    seq_det_frame_ctrl #(.W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .det_rst(det_rst_a), .det_en(det_en_a),
        .det_x(det_x_a), .det_z(det_z_a), .res_valid(res_valid_a), .res_ready(res_ready),
        .res_count(res_count_a), .res_sat(res_sat_a)
    );

    seq_det_frame_ctrl #(.W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .det_rst(det_rst_b), .det_en(det_en_b),
        .det_x(det_x_b), .det_z(det_z_b), .res_valid(res_valid_b), .res_ready(res_ready),
        .res_count(res_count_b), .res_sat(res_sat_b)
    );

    // 1100 overlapping Mealy detector: 0 = idle, 1 = "1", 2 = "11", 3 = "110".
    function automatic logic [1:0] det_next(input logic [1:0] st, input logic x);
        case (st)
            2'd0:    det_next = x ? 2'd1 : 2'd0;
            2'd1:    det_next = x ? 2'd2 : 2'd0;
            2'd2:    det_next = x ? 2'd2 : 2'd3;
            default: det_next = x ? 2'd1 : 2'd0;
        endcase
    endfunction

    logic [1:0] st_a, st_b;

    always @(posedge clk or posedge det_rst_a) begin
        if (det_rst_a) begin
            st_a <= 2'd0; det_z_a <= 1'b0;
        end else if (det_en_a) begin
            det_z_a <= (st_a == 2'd3) && !det_x_a;
            st_a    <= det_next(st_a, det_x_a);
        end else begin
            det_z_a <= 1'b0;
        end
    end

    always @(posedge clk or posedge det_rst_b) begin
        if (det_rst_b) begin
            st_b <= 2'd0; det_z_b <= 1'b0;
        end else if (det_en_b) begin
            det_z_b <= (st_b == 2'd3) && !det_x_b;
            st_b    <= det_next(st_b, det_x_b);
        end else begin
            det_z_b <= 1'b0;
        end
    end

    // Scoreboard consumer: serial bits and frame results
    always @(negedge clk) begin
        if (rst_n) begin
            if (det_rst_a) rst_pulses = rst_pulses + 1;
            if (det_en_a) begin
                bit eb;
                last_shift_cyc = cyc;
                vectors = vectors + 1;
                if (bit_q.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL det_x_unexpected: det_en=1 with no bit expected (det_x=%0b)", det_x_a);
                end else begin
                    eb = bit_q.pop_front();
                    if (det_x_a !== eb || det_x_b !== eb) begin
                        miscompares = miscompares + 1;
                        $display("FAIL det_x: got a=%0b b=%0b expected %0b", det_x_a, det_x_b, eb);
                    end
                end
            end
            if (res_valid_a && res_ready) begin
                exp_t e;
                vectors = vectors + 1;
                if (res_q.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL result_unexpected: transfer with count=%0d and no result expected", res_count_a);
                end else begin
                    e = res_q.pop_front();
                    if (res_count_a !== 8'(e.ca) || res_sat_a !== e.sa ||
                        res_count_b !== 2'(e.cb) || res_sat_b !== e.sb || res_valid_b !== 1'b1) begin
                        miscompares = miscompares + 1;
                        $display("FAIL result: got a=%0d/%0b b=%0d/%0b valid_b=%0b expected a=%0d/%0b b=%0d/%0b",
                                 res_count_a, res_sat_a, res_count_b, res_sat_b, res_valid_b,
                                 e.ca, e.sa, e.cb, e.sb);
                    end
                end
            end
        end
    end

    // Expected result for fw[0..nw-1], pushed when the frame is driven
    task automatic push_result(input int nw);
        logic [1:0] st;
        int   hits;
        exp_t e;
        st = 2'd0;
        hits = 0;
        for (int i = 0; i < nw; i++) begin
            for (int b = 7; b >= 0; b--) begin
                if (st == 2'd3 && !fw[i][b]) hits++;
                st = det_next(st, fw[i][b]);
            end
        end
        e.ca = (hits > 255) ? 255 : hits;
        e.sa = (hits > 255);
        e.cb = (hits > 3) ? 3 : hits;
        e.sb = (hits > 3);
        res_q.push_back(e);
    endtask

    task automatic send_word(input logic [7:0] data, input logic last);
        int t;
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready_a && t < 100);
        if (!in_ready_a) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL in_ready_timeout: in_ready=%0b expected 1 within 100 cycles", in_ready_a);
            in_valid = 1'b0;
            return;
        end
        for (int b = 7; b >= 0; b--) bit_q.push_back(data[b]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_load(output bit ok);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready_a && t < 100);
        ok = in_ready_a;
    endtask

    task automatic run_frame(input int nw, input int gap);
        bit ok;
        bit bad;
        push_result(nw);
        for (int i = 0; i < nw; i++) begin
            send_word(fw[i], i == nw - 1);
            if (gap > 0 && i < nw - 1) begin
                wait_load(ok);
                bad = !ok;
                for (int g = 0; g < gap; g++) begin
                    if (det_en_a !== 1'b0 || det_x_a !== 1'b0 || in_ready_a !== 1'b1) bad = 1'b1;
                    @(negedge clk);
                end
                vectors = vectors + 1;
                if (bad) begin
                    miscompares = miscompares + 1;
                    $display("FAIL gap_idle: det_en=%0b in_ready=%0b during gap, expected 0/1", det_en_a, in_ready_a);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_result(input int hold);
        int t;
        logic [7:0] c0;
        logic       s0;
        bit         bad;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!res_valid_a && t < 200);
        vectors = vectors + 1;
        if (!res_valid_a) begin
            miscompares = miscompares + 1;
            $display("FAIL res_valid_timeout: res_valid=%0b expected 1 within 200 cycles", res_valid_a);
            return;
        end
        if (cyc - last_shift_cyc !== 2) begin
            miscompares = miscompares + 1;
            $display("FAIL res_latency: res_valid %0d cycles after last shift, expected 2", cyc - last_shift_cyc);
        end
        c0 = res_count_a;
        s0 = res_sat_a;
        if (hold > 0) begin
            bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (res_valid_a !== 1'b1 || res_count_a !== c0 || res_sat_a !== s0 || in_ready_a !== 1'b0)
                    bad = 1'b1;
            end
            vectors = vectors + 1;
            if (bad) begin
                miscompares = miscompares + 1;
                $display("FAIL report_hold: valid=%0b count=%0d sat=%0b in_ready=%0b expected 1/%0d/%0b/0",
                         res_valid_a, res_count_a, res_sat_a, in_ready_a, c0, s0);
            end
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        vectors = vectors + 1;
        if (res_valid_a !== 1'b0 || in_ready_a !== 1'b0 || det_rst_a !== 1'b0 || res_q.size() !== 0) begin
            miscompares = miscompares + 1;
            $display("FAIL after_transfer: valid=%0b in_ready=%0b det_rst=%0b pending=%0d expected 0/0/0/0",
                     res_valid_a, in_ready_a, det_rst_a, res_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors = vectors + 1;
        if (in_ready_a !== 1'b0 || det_en_a !== 1'b0 || det_x_a !== 1'b0 || res_valid_a !== 1'b0 ||
            res_count_a !== 8'd0 || res_sat_a !== 1'b0 || det_rst_a !== 1'b1 ||
            res_count_b !== 2'd0 || res_sat_b !== 1'b0 || det_rst_b !== 1'b1) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: in_ready=%0b det_en=%0b det_x=%0b res_valid=%0b count=%0d sat=%0b det_rst=%0b expected 0/0/0/0/0/0/1",
                     name, in_ready_a, det_en_a, det_x_a, res_valid_a, res_count_a, res_sat_a, det_rst_a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; res_ready = 1'b0;
        #1;
        check_reset_outputs("reset_values");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors = vectors + 1;
        if (det_rst_a !== 1'b0 || in_ready_a !== 1'b0 || res_valid_a !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL post_release: det_rst=%0b in_ready=%0b res_valid=%0b expected 0/0/0",
                     det_rst_a, in_ready_a, res_valid_a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_word();
        fw[0] = 8'hCC;
        run_frame(1, 0);
        wait_result(0);
    endtask

    task automatic test_gap_boundary();
        fw[0] = 8'h03;
        fw[1] = 8'h3F;
        run_frame(2, 10);
        wait_result(0);
    endtask

    task automatic test_back_to_back();
        rst_pulses = 0;
        fw[0] = 8'h0C;
        run_frame(1, 0);
        wait_result(0);
        fw[0] = 8'hC0;
        run_frame(1, 0);
        wait_result(0);
        vectors = vectors + 1;
        if (rst_pulses !== 2) begin
            miscompares = miscompares + 1;
            $display("FAIL det_rst_pulses: got %0d expected 2", rst_pulses);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) fw[i] = 8'hCC;
        run_frame(4, 0);
        wait_result(0);
    endtask

    task automatic test_report_hold();
        fw[0] = 8'h6C;
        run_frame(1, 0);
        wait_result(5);
    endtask

    task automatic test_mid_reset();
        exp_t dropped;
        send_word(8'hCC, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_shift_reset");
        bit_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fw[0] = 8'hCC;
        run_frame(1, 0);
        wait_result(0);
        if (res_q.size() != 0) dropped = res_q.pop_front();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gap_boundary();
        test_back_to_back();
        test_saturation();
        test_report_hold();
        test_mid_reset();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_det_frame_ctrl.md
# seq_det_frame_ctrl

Frame sequencer for the gated 1100 Mealy sequence detector. Accepts parallel words over a valid/ready handshake, serialises them MSB-first into the detector one bit per enabled cycle, and counts detector pulses over a frame. At frame end it presents the hit count on a result handshake. It clears the detector at every frame start, so detections never span frames.

## Interface
- `W`, 8: input word width, ≥2.
- `CNT_W`, 8: result counter width, ≥1.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  controller accepts `in_data` this cycle.
- `in_data`  in  W  word, serialised MSB first.
- `in_last`  in  1  word is the final word of its frame; sampled with `in_data`.
- `det_rst`  out  1  active-high detector reset.
- `det_en`  out  1  `det_x` is a valid bit this cycle; the detector holds its state when 0.
- `det_x`  out  1  serial bit to the detector.
- `det_z`  in  1  detector hit pulse, registered: appears the cycle after the enabled bit that completes 1100.
- `res_valid`  out  1  frame result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_count`  out  CNT_W  detections in the frame, saturating.
- `res_sat`  out  1  count saturated during the frame.

## Operation
- FSM states: IDLE, CLR, LOAD, SHIFT, DRAIN, REPORT. Reset state is IDLE.
- IDLE
  - `in_ready`=0.
  - `in_valid`=1 → CLR. The pending word is not consumed.
- CLR (1 cycle)
  - `det_rst`=1.
  - Hit counter and `res_sat` cleared.
  - → LOAD.
- LOAD
  - `in_ready`=1.
  - On `in_valid`: capture `in_data` into the shift register, capture `in_last`, load the bit counter with W-1 → SHIFT.
  - With no `in_valid`, stay in LOAD with `det_en`=0. Upstream gaps are legal and do not disturb detector state.
- SHIFT
  - `det_en`=1 and `det_x`=shift register MSB.
  - Shift left and decrement the bit counter every cycle.
  - When the counter reaches 0: captured `in_last`=1 → DRAIN, else → LOAD.
- DRAIN (1 cycle)
  - `det_en`=0.
  - Catches the registered `det_z` for the final bit.
  - → REPORT.
- REPORT
  - `res_valid`=1.
  - `res_count` and `res_sat` held stable.
  - `in_ready`=0.
  - `res_ready`=1 → IDLE.
- Hit counting
  - `det_z`=1 is counted in LOAD, SHIFT and DRAIN only. It is ignored in IDLE, CLR and REPORT.
  - The counter saturates at 2^CNT_W-1. An increment attempted at the maximum sets `res_sat`=1, which stays set until the next CLR.
- Outputs are Moore decodes of the state plus datapath registers.
  - `det_x`=0 whenever `det_en`=0.
  - `det_rst`=(state==CLR) OR (rst_n==0), so the detector is held in reset while `rst_n` is low.
- Reset mid-operation: asynchronously
  - returns the FSM to IDLE;
  - clears the shift register, bit counter, hit counter and `res_sat`;
  - discards any in-flight frame or unread result.

## Timing
- Reset values
  - `in_ready`=0, `det_en`=0, `det_x`=0, `res_valid`=0, `res_count`=0, `res_sat`=0.
  - `det_rst`=1 while `rst_n`=0, and 0 in the first cycle after release (state IDLE).
- Frame start: `in_valid` seen in IDLE at cycle t → CLR at t+1 → LOAD at t+2. The first word is accepted no earlier than t+2.
- Word accepted on edge e:
  - SHIFT occupies the W cycles after e, `det_x` = bit W-1 … bit 0.
  - The next LOAD cycle follows, giving one bubble cycle per word.
  - Throughput is W bits per W+1 cycles with upstream always valid.
- Last word accepted on edge e:
  - DRAIN at cycle e+W+1, `res_valid`=1 from cycle e+W+2.
  - A hit on the last bit is included in `res_count`.
- Result handshake: transfer occurs on the edge with `res_valid` and `res_ready` both high. `res_valid` drops the next cycle, and that cycle is IDLE.
- `in_ready` never depends combinationally on `in_valid`. `res_valid` never depends on `res_ready`.

## Test plan
- Single word 0xCC with `in_last`=1, W=8: `det_x` = 1,1,0,0,1,1,0,0 on consecutive enabled cycles → `res_count`=2, `res_sat`=0, `res_valid` 2 cycles after the last SHIFT cycle.
- Words 0x03 then 0x3F (last), pattern spanning a word boundary, with a 10-cycle `in_valid` gap between them: `det_en`=0 throughout the gap → `res_count`=1.
- Two back-to-back frames: 0x0C (last) then 0xC0 (last). `det_rst` pulses once before each frame → counts 1 and 1. No carry-over of detector state.
- CNT_W=2, four 0xCC words in one frame (8 hits) → `res_count`=3, `res_sat`=1.
- Hold `res_ready`=0 for 5 cycles in REPORT: `res_valid`, `res_count` and `res_sat` are stable and `in_ready`=0. Release → one transfer, then IDLE.
- Assert `rst_n`=0 in the 4th SHIFT cycle: all outputs take their reset values immediately and `det_rst`=1. A new 0xCC frame afterwards → `res_count`=2.
